// File: rtl/tdm_demux1to4_if.sv
// ----------------------------------------------------------------------------
// tdm_demux1to4_if
// Bundle of signals between a serial TDM link (plus its consumers) and the
// tdm_demux1to4 receiver.
//   din_valid   : a sample beat is present on din this cycle
//   sync        : frame marker, qualified by din_valid, marks the slot-0 beat
//   din         : serial sample, W bits
//   out         : last complete frame, out[k*W +: W] = channel k
//   frame_valid : one-cycle pulse, out updated at this edge
//   slot        : slot index the next accepted beat will fill
//   locked      : receiver is frame-locked
//   sync_err    : one-cycle pulse on a framing violation
// Modports: master = link/consumer side, slave = receiver.
// ----------------------------------------------------------------------------
interface tdm_demux1to4_if #(
    parameter int W = 1
);
    logic           din_valid;
    logic           sync;
    logic [W-1:0]   din;
    logic [4*W-1:0] out;
    logic           frame_valid;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;

    modport master (
        output din_valid, sync, din,
        input  out, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din_valid, sync, din,
        output out, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux1to4.sv
// ----------------------------------------------------------------------------
// tdm_demux1to4
// Receive end of a 4-slot serial TDM link. Hunts for the frame marker, then
// deposits each W-bit beat into channel register k (k = slot index) and
// publishes the full 4-channel word with a one-cycle frame strobe once the
// slot-3 beat arrives. Partial frames never reach the output.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux1to4_if.slave (serial input, parallel output, status)
// ----------------------------------------------------------------------------
module tdm_demux1to4 #(
    parameter int W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    tdm_demux1to4_if.slave      bus
);

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [1:0]         r_slot,   w_slot_nxt;
    // Slots 0..2 are held here until slot 3 arrives; slot 3 goes straight
    // from din into the output word.
    logic [2:0][W-1:0]  r_shadow, w_shadow_nxt;
    logic [4*W-1:0]     r_out,    w_out_nxt;
    logic               r_fv,     w_fv_nxt;
    logic               r_err,    w_err_nxt;

    // ------------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HUNT;
            r_slot   <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_shadow <= w_shadow_nxt;
            r_out    <= w_out_nxt;
            r_fv     <= w_fv_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // Idle cycles hold everything except the two pulse outputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_shadow_nxt = r_shadow;
        w_out_nxt    = r_out;
        w_fv_nxt     = 1'b0;
        w_err_nxt    = 1'b0;

        if (bus.din_valid) begin
            unique case (r_state)
                S_HUNT: begin
                    if (bus.sync) begin
                        w_shadow_nxt[0] = bus.din;
                        w_slot_nxt      = 2'd1;
                        w_state_nxt     = S_LOCKED;
                    end
                end

                S_LOCKED: begin
                    if (r_slot == 2'd0) begin
                        if (bus.sync) begin
                            w_shadow_nxt[0] = bus.din;
                            w_slot_nxt      = 2'd1;
                        end else begin
                            // Marker missing where one was due: drop lock.
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_HUNT;
                            w_slot_nxt  = 2'd0;
                        end
                    end else if (bus.sync) begin
                        // Early marker: abandon the partial frame and treat
                        // this beat as slot 0 of a fresh one.
                        w_err_nxt       = 1'b1;
                        w_shadow_nxt[0] = bus.din;
                        w_slot_nxt      = 2'd1;
                    end else begin
                        unique case (r_slot)
                            2'd1: begin
                                w_shadow_nxt[1] = bus.din;
                                w_slot_nxt      = 2'd2;
                            end
                            2'd2: begin
                                w_shadow_nxt[2] = bus.din;
                                w_slot_nxt      = 2'd3;
                            end
                            default: begin
                                // slot 3 completes the frame
                                w_out_nxt  = {bus.din, r_shadow};
                                w_fv_nxt   = 1'b1;
                                w_slot_nxt = 2'd0;
                            end
                        endcase
                    end
                end

                default: begin
                    w_state_nxt = S_HUNT;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------------
    assign bus.out         = r_out;
    assign bus.frame_valid = r_fv;
    assign bus.sync_err    = r_err;
    assign bus.slot        = r_slot;
    assign bus.locked      = (r_state == S_LOCKED);

endmodule

// File: tb/tb_tdm_demux1to4.sv
module tb_tdm_demux1to4;

    localparam int W = 1;

    logic clk;
    logic rst_n;

    tdm_demux1to4_if #(.W(W)) bus ();

    tdm_demux1to4 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [3:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fv     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected event whenever the DUT pulses an output.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (bus.frame_valid && bus.sync_err) begin
                n_errors++;
                $display("FAIL pulse_overlap: frame_valid and sync_err both high at %0t", $time);
            end
            if (bus.frame_valid || bus.sync_err) begin
                n_checks++;
                if (bus.frame_valid) n_fv++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event: fv=%0b err=%0b with nothing expected at %0t",
                             bus.frame_valid, bus.sync_err, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_err != bus.sync_err) begin
                        n_errors++;
                        $display("FAIL event_kind: got sync_err=%0b expected %0b at %0t",
                                 bus.sync_err, e.is_err, $time);
                    end else if (!e.is_err && bus.out !== e.val) begin
                        n_errors++;
                        $display("FAIL frame_out: got %b expected %b at %0t", bus.out, e.val, $time);
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [3:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = v;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.val    = '0;
        exp_q.push_back(e);
    endtask

    // One beat: inputs are set between edges, taken at the next rising edge.
    task automatic send(input logic s, input logic d);
        bus.din_valid = 1'b1;
        bus.sync      = s;
        bus.din       = d;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int fv_base;

    initial begin
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.din       = '0;
        idle(2);
        chk("reset_out",    bus.out, 0);
        chk("reset_fv",     bus.frame_valid, 0);
        chk("reset_err",    bus.sync_err, 0);
        chk("reset_slot",   bus.slot, 0);
        chk("reset_locked", bus.locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lock and capture
        send(1'b1, 1'b1);
        chk("lock_locked", bus.locked, 1);
        chk("lock_slot",   bus.slot, 1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        push_frame(4'b1101);
        send(1'b0, 1'b1);
        chk("cap_out", bus.out, 4'b1101);
        chk("cap_fv",  bus.frame_valid, 1);
        chk("cap_slot", bus.slot, 0);
        idle(1);
        chk("cap_fv_drop", bus.frame_valid, 0);

        // Missing marker at slot 0
        push_err();
        send(1'b0, 1'b0);
        chk("miss_err",    bus.sync_err, 1);
        chk("miss_locked", bus.locked, 0);
        chk("miss_slot",   bus.slot, 0);
        idle(1);
        chk("miss_err_drop", bus.sync_err, 0);

        // Hunt discard then relock
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        chk("hunt_locked", bus.locked, 0);
        chk("hunt_slot",   bus.slot, 0);
        chk("hunt_out",    bus.out, 4'b1101);

        // Gapped and back-to-back traffic: 1101, 0110 (gap), 1111
        fv_base = n_fv;
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        push_frame(4'b1101);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        chk("b2b_out1", bus.out, 4'b1101);
        send(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("gap_slot", bus.slot, 2);
        end
        send(1'b0, 1'b1);
        push_frame(4'b0110);
        send(1'b0, 1'b0);
        chk("b2b_out2", bus.out, 4'b0110);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        push_frame(4'b1111);
        send(1'b0, 1'b1);
        chk("b2b_out3", bus.out, 4'b1111);
        idle(1);
        chk("b2b_fv_count", n_fv - fv_base, 3);

        // Early marker after slots 1 and 2
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        push_err();
        send(1'b1, 1'b0);
        chk("early_err",  bus.sync_err, 1);
        chk("early_out",  bus.out, 4'b1111);
        chk("early_slot", bus.slot, 1);
        chk("early_locked", bus.locked, 1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        push_frame(4'b1000);
        send(1'b0, 1'b1);
        chk("early_out2", bus.out, 4'b1000);

        // Async reset mid-frame
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        chk("pre_rst_slot", bus.slot, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out",    bus.out, 0);
        chk("arst_slot",   bus.slot, 0);
        chk("arst_locked", bus.locked, 0);
        chk("arst_fv",     bus.frame_valid, 0);
        chk("arst_err",    bus.sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        chk("post_rst_locked", bus.locked, 0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        push_frame(4'b1010);
        send(1'b0, 1'b1);
        chk("post_rst_out", bus.out, 4'b1010);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux1to4.md
# tdm_demux1to4

Time-division demultiplexer: the receive end of a 4-slot serial link driven by a 4-to-1 mux transmitter that walks its select 0→1→2→3. The block locks onto a frame marker and deposits each incoming W-bit sample into channel register k, where k is the slot index (the transmitter's select value). It presents the completed 4-channel word in parallel with a one-cycle frame strobe. It sits between the serial link and the per-channel consumers.

## Interface
- `W`, default 1, width of one channel sample in bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `din_valid`  input  1  a sample beat is present on `din` this cycle.
- `sync`  input  1  frame marker; meaningful only when `din_valid`=1; marks the slot-0 beat.
- `din`  input  W  serial sample.
- `out`  output  4*W  last complete frame; `out[k*W +: W]` = channel k.
- `frame_valid`  output  1  one-cycle pulse: `out` was updated at this edge.
- `slot`  output  2  slot index the next accepted beat will fill.
- `locked`  output  1  1 while in LOCKED state.
- `sync_err`  output  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT (reset state), LOCKED.
- Beat = cycle with `din_valid`=1. Cycles with `din_valid`=0 change nothing except clearing the pulse outputs.
- HUNT:
  - Beat with `sync`=0 is discarded.
  - Beat with `sync`=1 stores `din` in shadow[0], sets `slot`=1, and moves to LOCKED.
- LOCKED, beat at `slot`=s:
  - s=0 and `sync`=1: store shadow[0], `slot`=1.
  - s=0 and `sync`=0: lock lost. Pulse `sync_err`, go to HUNT, set `slot`=0, discard the beat.
  - s∈{1,2} and `sync`=0: store shadow[s], `slot`=s+1.
  - s=3 and `sync`=0: load `out` ← {din, shadow[2], shadow[1], shadow[0]}, pulse `frame_valid`, and wrap `slot` to 0.
  - s∈{1,2,3} and `sync`=1 (early marker): pulse `sync_err` and discard the partial frame; `out` is unchanged. Treat the beat as a new slot 0: store shadow[0], `slot`=1, stay LOCKED.
- `out` only ever changes on a slot-3 beat. A partial frame never reaches `out`.
- Shadow registers are internal. Their content after a discard is don't-care.

## Timing
- Reset (asynchronous, active low) forces:
  - `out`=0, `frame_valid`=0, `sync_err`=0, `slot`=0, `locked`=0;
  - state HUNT; shadow registers 0.
- All outputs are registered and update on the rising edge that accepts the beat.
- Latency: the slot-3 beat is accepted at edge N. `out` and `frame_valid`=1 are visible after edge N. `frame_valid` returns to 0 after edge N+1, unless that edge completes another frame.
- Back-to-back frames (4 consecutive beats per frame, no idle) give `frame_valid` high exactly every 4th cycle.
- `sync_err` is high for exactly one cycle per violation. `frame_valid` and `sync_err` are never high together.
- `locked` rises after the edge accepting the first sync beat. It falls after the edge that detects a missing marker.
- Reset asserted mid-frame takes effect immediately and asynchronously. After release, the block re-hunts; no stale `frame_valid` is produced.
- Idle gaps of any length between beats are legal. Slot position is held across the gap.

## Test plan
- Lock and capture, W=1: release reset. Send beats (sync,din) = (1,1),(0,0),(0,1),(0,1) → after the 4th edge `out`=4'b1101 and `frame_valid`=1 for one cycle; `locked`=1 from the 1st beat onward; `sync_err`=0 throughout.
- Hunt discard: send beats 1,1 with `sync`=0, then the frame above → no `frame_valid` before the frame; `out`=4'b1101 after its 4th beat; `locked`=0 until the sync beat.
- Gapped and back-to-back traffic: send frame 1101, then frame 0110 (slot0=0, slot1=1, slot2=1, slot3=0) with idle cycles between beats 2 and 3, then frame 1111 with no gap → `out` goes 4'b1101, then 4'b0110, then 4'b1111; exactly 3 `frame_valid` pulses; `slot` holds its value during the idle cycles.
- Early marker: after slot-1 and slot-2 beats, send `sync`=1 with din=0 → `sync_err` pulses once; `out` keeps its previous value; `slot`=1; completing beats 0,0,1 yield `out`=4'b1000.
- Missing marker: while locked, send a slot-0 beat with `sync`=0 → `sync_err` pulses; `locked`=0; `slot`=0; the next sync frame relocks and delivers correctly.
- Async reset mid-frame: pull `rst_n` low between clock edges after slot 2 → all outputs go to 0 immediately; after release, a full sync frame is needed before any `frame_valid`.
